// File: rtl/ni_rx.sv
`default_nettype none
// ============================================================================
// Module      : ni_rx
// Description : Receive-side network interface. Accepts spike packets from the
//               local router port. It keeps packets addressed to this router
//               or to the broadcast address, and drops all others. Kept neuron
//               addresses are buffered in a first-word-fall-through FIFO that
//               the core pops. Saturating receive and drop counters are kept.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_rx #(
    parameter int ADDRSIZE = 5,
    parameter int MSB_SLOT = 5,
    parameter int CNTW     = 16,
    localparam int DSIZE   = 1 << MSB_SLOT,
    localparam int RSIZE   = 1 << (MSB_SLOT - 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RSIZE-1:0] router_id,
    input  logic [DSIZE-1:0] ni_rdata,
    input  logic             ni_rvalid,
    output logic             ni_rfull,
    output logic [RSIZE-1:0] core_rdata,
    output logic             core_rempty,
    input  logic             core_rinc,
    output logic [CNTW-1:0]  rx_cnt,
    output logic [CNTW-1:0]  drop_cnt
);

    localparam int                c_DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] c_FULL  = {1'b1, {ADDRSIZE{1'b0}}};

    logic [RSIZE-1:0]    r_mem [c_DEPTH];
    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic [RSIZE-1:0]    r_rdata;
    logic [CNTW-1:0]     r_rx_cnt;
    logic [CNTW-1:0]     r_drop_cnt;

    logic                w_full;
    logic                w_empty;
    logic [RSIZE-1:0]    w_dest;
    logic [RSIZE-1:0]    w_neuron;
    logic                w_match;
    logic                w_take;
    logic                w_wr;
    logic                w_drop;
    logic                w_rd;
    logic [ADDRSIZE-1:0] w_rptr_nxt;
    logic                w_load_in;

    // Status flags come from the occupancy register only, so backpressure
    // never depends combinationally on the core's pop request.
    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);

    assign w_dest      = ni_rdata[DSIZE-1:RSIZE];
    assign w_neuron    = ni_rdata[RSIZE-1:0];
    assign w_match     = (w_dest == router_id) || (w_dest == {RSIZE{1'b1}});

    // A full FIFO refuses every packet, even ones that would be dropped.
    assign w_take      = ni_rvalid & ~w_full;
    assign w_wr        = w_take & w_match;
    assign w_drop      = w_take & ~w_match;
    assign w_rd        = core_rinc & ~w_empty;
    assign w_rptr_nxt  = r_rptr + 1'b1;

    // The incoming address becomes the head directly when nothing older will
    // remain in the FIFO after this edge.
    assign w_load_in   = w_wr & (w_empty | (w_rd & (r_count == {{ADDRSIZE{1'b0}}, 1'b1})));

    // Storage array; no reset needed since occupancy gates all reads.
    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_mem[r_wptr] <= w_neuron;
        end
    end

    // Pointers and occupancy count; both pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered head-of-FIFO output for glitch-free fall-through data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_load_in) begin
            r_rdata <= w_neuron;
        end else if (w_rd) begin
            r_rdata <= r_mem[w_rptr_nxt];
        end
    end

    // Saturating statistics counters for kept and dropped packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr && (r_rx_cnt != {CNTW{1'b1}})) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != {CNTW{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign ni_rfull    = w_full;
    assign core_rempty = w_empty;
    assign core_rdata  = r_rdata;
    assign rx_cnt      = r_rx_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/ni_rx.md
Name: ni_rx

Overview:
Receive-side network interface: the NoC-to-core counterpart of the core-to-NoC write path.
- Accepts DSIZE-bit spike packets from the local router port, formatted as {dest router address [DSIZE-1:RSIZE], neuron address [RSIZE-1:0]}.
- Keeps packets addressed to this router, or to the broadcast address, and drops all others.
- Buffers kept neuron addresses in a first-word-fall-through (FWFT) FIFO that the core pops.
- Keeps saturating receive and drop statistics counters.

Parameters:
ADDRSIZE, 5, FIFO pointer width; FIFO depth DEPTH = 1<<ADDRSIZE = 32 entries
MSB_SLOT, 5, packet size exponent; DSIZE = 1<<MSB_SLOT = 32, RSIZE = 1<<(MSB_SLOT-1) = 16
CNTW, 16, width of the statistics counters

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
router_id  input  RSIZE  this router's address; quasi-static
ni_rdata  input  DSIZE  packet from NoC: [DSIZE-1:RSIZE] = dest router, [RSIZE-1:0] = neuron address
ni_rvalid  input  1  ni_rdata valid this cycle
ni_rfull  output  1  backpressure to NoC; when high, no packet is taken
core_rdata  output  RSIZE  neuron address at the FIFO head
core_rempty  output  1  FIFO empty; core_rdata is invalid when high
core_rinc  input  1  core pops the head entry this cycle
rx_cnt  output  CNTW  count of packets kept (matched or broadcast), saturating
drop_cnt  output  CNTW  count of packets dropped on address mismatch, saturating

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - Pointers and occupancy count go to 0.
  - ni_rfull=0, core_rempty=1, core_rdata=0, rx_cnt=0, drop_cnt=0.
  - Reset asserted mid-operation discards all buffered entries; anything presented in that cycle is ignored.
- Occupancy is held in a count register, ADDRSIZE+1 bits wide. Read and write pointers are ADDRSIZE bits wide and wrap modulo DEPTH with no special handling.
- ni_rfull = (count == DEPTH), decoded from registered state only; there is no combinational path from core_rinc.
- core_rempty = (count == 0), decoded from registered state.
- A packet is taken at a rising edge when ni_rvalid=1 and ni_rfull=0. It is then classified on dest = ni_rdata[DSIZE-1:RSIZE]:
  - If dest == router_id or dest == all-ones: the neuron address ni_rdata[RSIZE-1:0] is written at the write pointer, the write pointer increments, and rx_cnt increments.
  - Otherwise the packet is discarded and drop_cnt increments. FIFO state is unchanged.
- When ni_rfull=1 every packet is refused, including ones that would be dropped. The NoC must hold the packet.
- When full, a simultaneous core_rinc does not allow a same-cycle write. ni_rfull deasserts in the cycle after the pop.
- Statistics counters saturate at all-ones and never wrap.
- Pop:
  - A pop occurs at a rising edge when core_rinc=1 and core_rempty=0: the read pointer increments and count decrements.
  - core_rinc while core_rempty=1 is ignored; there is no underflow and state is unchanged.
- FWFT output:
  - core_rdata equals the memory entry at the read pointer, registered so it stays glitch-free.
  - Latency: a packet taken at edge N into an empty FIFO gives core_rempty=0 and core_rdata equal to its neuron address after edge N, i.e. in cycle N+1.
  - After a pop at edge N, core_rdata shows the next entry in cycle N+1.
- Simultaneous kept write and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Simultaneous write and pop with count == 1: the new entry becomes the head in the next cycle and core_rempty stays 0.
- A dropped packet in the same cycle as a pop: only the pop affects the FIFO.
- While core_rempty=1, core_rdata holds its last value and is don't-care.
- Output register update rule, in priority order:
  1. A write into an empty FIFO, or a write with a pop at count == 1, loads the incoming neuron address.
  2. Otherwise a pop loads the memory entry at read pointer + 1.
  3. Otherwise core_rdata holds.

Test Plan:
1. Reset, router_id=16'h0003, send 32'h0003_00A5 -> core_rempty falls the cycle after acceptance, core_rdata=16'h00A5, rx_cnt=1, drop_cnt=0. Then core_rinc=1 for one cycle -> core_rempty=1.
2. Send 32'h0007_0011 (mismatch) then 32'hFFFF_0022 (broadcast) -> drop_cnt=1, rx_cnt=1, only 16'h0022 readable.
3. Send 32 matched packets with neuron addresses 0..31 and no pops -> ni_rfull=1 after the 32nd. Hold a 33rd packet with ni_rvalid=1 -> not taken. Pop one -> ni_rfull=0 the next cycle and the 33rd is taken. Drain and check order 1..32.
4. Stream 100 matched packets with core_rinc=1 every cycle -> count never exceeds 1, no loss, order preserved, pointers wrap, rx_cnt=100.
5. core_rinc pulses while empty -> no state change, core_rempty stays 1. Simultaneous write and pop at count=1 -> core_rdata updates to the new address and core_rempty stays 0.
6. Fill 10 entries, assert reset for one cycle -> core_rempty=1, ni_rfull=0, both counters 0. Force drop_cnt to near-saturation with 16'hFFFF mismatches (CNTW=4 variant) -> counter holds at 4'hF.
